net_tx_arbiter: RTL and testbench
=================================

NET_TX_ARBITER -- requirements
Module: net_tx_arbiter

Interface
REQ-001 SHALL provide parameter PACKET_SIZE, default 16: payload bytes per packet, range 2..1023.
REQ-002 SHALL provide port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL provide port reset, input, 1: asynchronous, active-low reset; 0 = in reset.
REQ-004 SHALL provide ports src0_count/src1_count, input, 11 each: source FIFO data counts.
REQ-005 SHALL provide ports src0_empty/src1_empty, input, 1 each: source FIFO empty flags.
REQ-006 SHALL provide ports src0_data/src1_data, input, 8 each: FIFO dout; valid one cycle after rd.
REQ-007 SHALL provide ports src0_phone/src1_phone, input, 8 each: destination number per source.
REQ-008 SHALL provide ports src0_rd/src1_rd, output, 1 each: single-cycle FIFO read strobes.
REQ-009 SHALL provide port net_ready, input, 1: network sink accepts a byte when high with net_valid.
REQ-010 SHALL provide ports net_data (output, 8), net_valid, net_sop and net_eop (outputs, 1 each): network byte stream.
REQ-011 SHALL provide ports grant (output, 2, one-hot or 0), busy (output, 1), underflow (output, 1, pulse) and pkt_count (output, 16).

Function
REQ-012 SHALL implement FSM states IDLE, HEADER, READ, WAIT, SEND, GAP.
REQ-013 IDLE: source eligible when count >= PACKET_SIZE and empty = 0; both eligible -> source not served last; one eligible -> that source; none -> stay.
REQ-014 On leaving IDLE: latch the granted source's phone, set grant, busy = 1, byte counter = 0, go HEADER.
REQ-015 HEADER: net_data = latched phone, net_valid = 1, net_sop = 1; hold until net_ready = 1, then go READ.
REQ-016 READ: assert the granted srcN_rd for exactly one cycle, go WAIT.
REQ-016a READ with granted src empty = 1: no rd; pulse underflow one cycle; go GAP with no eop; pkt_count unchanged.
REQ-017 WAIT: register the granted srcN_data into an output holding register, go SEND.
REQ-018 SEND: net_data = held byte, net_valid = 1; net_eop = 1 when byte counter = PACKET_SIZE-1; hold all outputs stable until net_ready = 1.
REQ-019 SEND accepted, not last: increment byte counter, go READ; last: increment pkt_count (wraps 0xFFFF -> 0), go GAP.
REQ-020 GAP: one cycle, net_valid = 0; record last-served source; clear grant and busy; go IDLE.
REQ-021 Never assert an srcN_rd other than the granted one, never assert both, never assert in IDLE/HEADER/WAIT/SEND/GAP.
REQ-022 Source eligibility changes after grant SHALL NOT affect the packet in progress; phone sampled only at grant.
REQ-023 net_sop and net_eop SHALL only be high with net_valid; per packet exactly 1 header + PACKET_SIZE payload bytes.
REQ-024 Minimum throughput with net_ready held high: 3 cycles per payload byte, packet length 1 + 1 + 3*PACKET_SIZE + 1 cycles IDLE-to-IDLE.

Reset
REQ-025 reset = 0 SHALL immediately force state IDLE, all srcN_rd = 0, net_valid/sop/eop = 0, net_data = 0, grant = 0, busy = 0, underflow = 0, pkt_count = 0, byte counter = 0, last-served = src1 (so src0 wins first tie).
REQ-026 Reset mid-packet SHALL abandon the packet without eop; the source FIFO remainder is not drained.
REQ-027 After reset release, first arbitration SHALL occur on the first clk edge with reset = 1.

Verification
REQ-028 src0_count=16, src1 empty, phone0=0x42, net_ready=1 -> bytes 0x42(sop), 16 payload bytes in FIFO order, eop on 16th, 16 src0_rd pulses, pkt_count=1.
REQ-029 Both counts=16 after reset -> src0 packet then src1 packet; both held eligible -> strict alternation 0,1,0,1.
REQ-030 net_ready low 5 cycles during byte 3 of SEND -> net_data/net_valid stable for those cycles, no extra rd, byte not duplicated or dropped.
REQ-031 src0_count=15 -> no grant; count reaches 16 -> grant within 1 cycle.
REQ-032 src0 forced empty at READ of byte 7 -> underflow pulse 1 cycle, no eop, pkt_count unchanged, return to IDLE via GAP.
REQ-033 reset low during byte 10 -> all outputs zero same cycle (asynchronous); after release, pkt_count=0 and src0 wins a tie.

Source files
------------

// File: rtl/net_tx_arbiter.sv
// Two-source packet arbiter: header byte (phone number) then PACKET_SIZE payload bytes from the granted FIFO.
// Round-robin on ties, 3 cycles per payload byte, outputs held stable while net_ready is low.
module net_tx_arbiter #(
  parameter int PACKET_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] src0_count,
  input  logic [10:0] src1_count,
  input  logic        src0_empty,
  input  logic        src1_empty,
  input  logic [7:0]  src0_data,
  input  logic [7:0]  src1_data,
  input  logic [7:0]  src0_phone,
  input  logic [7:0]  src1_phone,
  output logic        src0_rd,
  output logic        src1_rd,
  input  logic        net_ready,
  output logic [7:0]  net_data,
  output logic        net_valid,
  output logic        net_sop,
  output logic        net_eop,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        underflow,
  output logic [15:0] pkt_count
);

  typedef enum logic [2:0] {IDLE, HEADER, READ, WAIT, SEND, GAP} state_t;

  localparam logic [10:0] PKT_LEN  = 11'(PACKET_SIZE);
  localparam logic [9:0]  LAST_IDX = 10'(PACKET_SIZE - 1);

  state_t      state;
  logic [9:0]  byte_cnt;
  logic        last_src;
  logic        elig0, elig1, pick1;
  logic        sel_empty;
  logic [7:0]  sel_data;

  assign elig0     = (src0_count >= PKT_LEN) && !src0_empty;
  assign elig1     = (src1_count >= PKT_LEN) && !src1_empty;
  assign pick1     = elig1 && (!elig0 || !last_src);
  assign sel_empty = grant[1] ? src1_empty : src0_empty;
  assign sel_data  = grant[1] ? src1_data  : src0_data;

  // Read strobes are decoded from registered state so an empty FIFO suppresses them in the same cycle.
  assign src0_rd = (state == READ) && grant[0] && !src0_empty;
  assign src1_rd = (state == READ) && grant[1] && !src1_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      last_src  <= 1'b1;
      net_data  <= '0;
      net_valid <= 1'b0;
      net_sop   <= 1'b0;
      net_eop   <= 1'b0;
      grant     <= '0;
      busy      <= 1'b0;
      underflow <= 1'b0;
      pkt_count <= '0;
    end else begin
      underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            // net_data doubles as the phone latch for the whole header phase.
            grant     <= pick1 ? 2'b10 : 2'b01;
            net_data  <= pick1 ? src1_phone : src0_phone;
            net_valid <= 1'b1;
            net_sop   <= 1'b1;
            busy      <= 1'b1;
            byte_cnt  <= '0;
            state     <= HEADER;
          end
        end
        HEADER: begin
          if (net_ready) begin
            net_valid <= 1'b0;
            net_sop   <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          if (sel_empty) begin
            underflow <= 1'b1;
            state     <= GAP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          net_data  <= sel_data;
          net_valid <= 1'b1;
          net_eop   <= (byte_cnt == LAST_IDX);
          state     <= SEND;
        end
        SEND: begin
          if (net_ready) begin
            net_valid <= 1'b0;
            net_eop   <= 1'b0;
            if (byte_cnt == LAST_IDX) begin
              pkt_count <= pkt_count + 16'd1;
              state     <= GAP;
            end else begin
              byte_cnt <= byte_cnt + 10'd1;
              state    <= READ;
            end
          end
        end
        GAP: begin
          last_src <= grant[1];
          grant    <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Bench for net_tx_arbiter: FIFO models, a stream scoreboard with a round-robin reference, vector table and corner sequences.
module tb_net_tx_arbiter;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] src0_count, src1_count;
  logic        src0_empty, src1_empty;
  logic [7:0]  src0_data = 8'h00, src1_data = 8'h00;
  logic [7:0]  src0_phone = 8'h42, src1_phone = 8'h77;
  logic        src0_rd, src1_rd;
  logic        net_ready = 1'b0;
  logic [7:0]  net_data;
  logic        net_valid, net_sop, net_eop;
  logic [1:0]  grant;
  logic        busy, underflow;
  logic [15:0] pkt_count;

  net_tx_arbiter #(.PACKET_SIZE(N)) dut (
    .clk(clk), .reset(reset),
    .src0_count(src0_count), .src1_count(src1_count),
    .src0_empty(src0_empty), .src1_empty(src1_empty),
    .src0_data(src0_data), .src1_data(src1_data),
    .src0_phone(src0_phone), .src1_phone(src1_phone),
    .src0_rd(src0_rd), .src1_rd(src1_rd),
    .net_ready(net_ready), .net_data(net_data), .net_valid(net_valid),
    .net_sop(net_sop), .net_eop(net_eop), .grant(grant), .busy(busy),
    .underflow(underflow), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents as seen by the DUT, and the bytes the scoreboard still expects per source
  logic [7:0] q0[$], q1[$], exp0[$], exp1[$];
  int         order[$];
  logic       ovr = 1'b0, force_e0 = 1'b0;
  logic [10:0] ovr_c0 = '0, ovr_c1 = '0;
  logic       ovr_e0 = 1'b1, ovr_e1 = 1'b1;

  // scoreboard state
  logic       prev_busy = 1'b0, prev_elig = 1'b0, m_last = 1'b1, cur = 1'b0;
  logic       snap_e0 = 1'b0, snap_e1 = 1'b0;
  logic [7:0] snap_ph0 = '0, snap_ph1 = '0, exp_hdr = '0;
  int         pay_n = 0, m_pkts = 0, rd_cnt = 0, uf_cnt = 0;

  typedef struct {
    logic [10:0] c0; logic e0; logic [10:0] c1; logic e1; logic [1:0] g;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd();
    src0_count = ovr ? ovr_c0 : 11'(q0.size());
    src1_count = ovr ? ovr_c1 : 11'(q1.size());
    src0_empty = force_e0 | (ovr ? ovr_e0 : (q0.size() == 0));
    src1_empty = ovr ? ovr_e1 : (q1.size() == 0);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push(input int src, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (src == 0) begin q0.push_back(b); exp0.push_back(b); end
      else begin q1.push_back(b); exp1.push_back(b); end
    end
  endtask

  task automatic rst_on();
    reset = 1'b0; net_ready = 1'b0; force_e0 = 1'b0; ovr = 1'b0;
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); order.delete();
    step(); step();
  endtask

  task automatic rst_off();
    step(); reset = 1'b1;
  endtask

  task automatic fifo_cycle();
    @(negedge clk);
    if (src0_rd && q0.size() > 0) src0_data = q0.pop_front();
    if (src1_rd && q1.size() > 0) src1_data = q1.pop_front();
    @(posedge clk); #1;
    upd();
  endtask

  task automatic mon_cycle();
    logic [1:0] eg;
    logic [7:0] eb;
    @(negedge clk);
    if (!reset) begin
      prev_busy = 1'b0; prev_elig = 1'b0; m_last = 1'b1; m_pkts = 0; pay_n = 0;
    end else begin
      chk("rd_legal", {31'd0, !(src0_rd && src1_rd) && (!src0_rd || (busy && grant == 2'b01))
                              && (!src1_rd || (busy && grant == 2'b10))}, 32'd1);
      chk("flags_need_valid", {31'd0, (!net_sop || net_valid) && (!net_eop || net_valid)}, 32'd1);
      if (src0_rd || src1_rd) rd_cnt++;
      if (underflow) uf_cnt++;
      if (busy && !prev_busy) begin
        eg = (snap_e0 && snap_e1) ? (m_last ? 2'b01 : 2'b10) : snap_e0 ? 2'b01 : snap_e1 ? 2'b10 : 2'b00;
        chk("grant_choice", {30'd0, grant}, {30'd0, eg});
        cur = grant[1];
        exp_hdr = cur ? snap_ph1 : snap_ph0;
        pay_n = 0;
        chk("hdr_flags", {30'd0, net_valid, net_sop}, 32'd3);
      end else if (!busy && !prev_busy && prev_elig) begin
        chk("grant_late", {31'd0, busy}, 32'd1);
      end
      if (busy && net_valid && net_ready) begin
        if (net_sop) begin
          chk("hdr_phone", {24'd0, net_data}, {24'd0, exp_hdr});
        end else begin
          eb = 8'hxx;
          if (cur == 1'b0 && exp0.size() > 0) eb = exp0.pop_front();
          if (cur == 1'b1 && exp1.size() > 0) eb = exp1.pop_front();
          chk("payload", {24'd0, net_data}, {24'd0, eb});
          chk("eop", {31'd0, net_eop}, {31'd0, pay_n == N - 1});
          pay_n++;
          if (net_eop) begin m_pkts++; order.push_back(int'(cur)); end
        end
      end
      if (!busy && prev_busy) begin
        chk("pkt_count", {16'd0, pkt_count}, 32'(m_pkts));
        m_last = cur;
      end
      if (!busy) begin
        snap_e0 = (src0_count >= 11'(N)) && !src0_empty;
        snap_e1 = (src1_count >= 11'(N)) && !src1_empty;
        snap_ph0 = src0_phone; snap_ph1 = src1_phone;
        prev_elig = snap_e0 || snap_e1;
      end else begin
        prev_elig = 1'b0;
      end
      prev_busy = busy;
    end
  endtask

  initial begin
    vec_t vt[7];
    int base, n;
    logic [7:0] held;
    vt[0] = '{16, 0, 16, 0, 2'b01};
    vt[1] = '{15, 0, 16, 0, 2'b10};
    vt[2] = '{16, 1, 16, 0, 2'b10};
    vt[3] = '{2047, 0, 0, 1, 2'b01};
    vt[4] = '{15, 0, 15, 0, 2'b00};
    vt[5] = '{16, 1, 16, 1, 2'b00};
    vt[6] = '{0, 1, 17, 0, 2'b10};
    upd();
    fork
      forever fifo_cycle();
      forever mon_cycle();
    join_none

    #3;
    chk("reset_outs", {10'd0, src0_rd, src1_rd, net_data, net_valid, net_sop, net_eop, grant, busy, underflow},
        32'd0);
    chk("reset_pkt_count", {16'd0, pkt_count}, 32'd0);

    // arbitration table, each vector right after reset (last-served = src1)
    foreach (vt[i]) begin
      rst_on();
      ovr = 1'b1; ovr_c0 = vt[i].c0; ovr_e0 = vt[i].e0; ovr_c1 = vt[i].c1; ovr_e1 = vt[i].e1;
      rst_off();
      step();
      chk($sformatf("tbl%0d_grant", i), {30'd0, grant}, {30'd0, vt[i].g});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].g != 2'b00});
    end

    // single packet from src0 at full rate, IDLE-to-IDLE timing
    rst_on(); src0_phone = 8'h42; push(0, N); rst_off(); net_ready = 1'b1;
    base = rd_cnt;
    for (int i = 0; i < 20 && !busy; i++) step();
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin step(); n++; end
    chk("pkt_cycles", 32'(n), 32'(3 * N + 2));
    chk("rd_pulses", 32'(rd_cnt - base), 32'(N));
    chk("single_pkt_count", {16'd0, pkt_count}, 32'd1);

    // both eligible: strict alternation starting with src0
    rst_on(); push(0, 2 * N); push(1, 2 * N); rst_off(); net_ready = 1'b1;
    for (int i = 0; i < 600 && m_pkts < 4; i++) step();
    chk("alt_pkts", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_order%0d", i), 32'(i < order.size() ? order[i] : -1), 32'(i % 2));

    // backpressure during the third payload byte
    rst_on(); push(0, N); rst_off(); net_ready = 1'b1;
    for (int i = 0; i < 100 && !(net_valid && !net_sop && pay_n == 2); i++) step();
    chk("stall_reached", {31'd0, net_valid && !net_sop}, 32'd1);
    net_ready = 1'b0; held = net_data; base = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {23'd0, net_valid, net_data}, {23'd0, 1'b1, held});
    end
    chk("stall_no_rd", 32'(rd_cnt - base), 32'd0);
    net_ready = 1'b1;
    for (int i = 0; i < 200 && (busy || m_pkts == 0); i++) step();
    chk("stall_pkt_count", {16'd0, pkt_count}, 32'd1);

    // count one short of a packet, then exactly a packet
    rst_on(); ovr = 1'b1; ovr_c0 = 11'd15; ovr_e0 = 1'b0; ovr_c1 = 11'd0; ovr_e1 = 1'b1; rst_off();
    for (int i = 0; i < 5; i++) step();
    chk("short_no_grant", {30'd0, grant}, 32'd0);
    ovr_c0 = 11'd16;
    step(); step();
    chk("full_grant", {30'd0, grant}, 32'd1);

    // source drains unexpectedly mid-packet
    rst_on(); push(0, N); rst_off(); net_ready = 1'b1; base = uf_cnt;
    for (int i = 0; i < 100 && !(net_valid && !net_sop && pay_n == 6); i++) step();
    force_e0 = 1'b1;
    for (int i = 0; i < 50 && uf_cnt == base; i++) step();
    for (int i = 0; i < 10 && busy; i++) step();
    chk("uf_pulses", 32'(uf_cnt - base), 32'd1);
    chk("uf_bytes", 32'(pay_n), 32'd7);
    chk("uf_pkt_count", {16'd0, pkt_count}, 32'd0);
    chk("uf_idle", {31'd0, busy}, 32'd0);
    force_e0 = 1'b0;

    // asynchronous reset during the tenth payload byte
    rst_on(); push(0, N); push(1, N); rst_off(); net_ready = 1'b1;
    for (int i = 0; i < 100 && !(net_valid && !net_sop && pay_n == 9); i++) step();
    chk("rst_reached", 32'(pay_n), 32'd9);
    reset = 1'b0; #1;
    chk("rst_async_outs", {10'd0, src0_rd, src1_rd, net_data, net_valid, net_sop, net_eop, grant, busy, underflow},
        32'd0);
    chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    rst_on(); push(0, N); push(1, N); rst_off();
    step();
    chk("rst_tie_src0", {30'd0, grant}, 32'd1);

    // randomized traffic against the scoreboard
    rst_on(); rst_off();
    for (int c = 0; c < 4000; c++) begin
      net_ready = ($urandom_range(0, 3) != 0);
      if (q0.size() < 100 && $urandom_range(0, 2) == 0) push(0, 1);
      if (q1.size() < 100 && $urandom_range(0, 2) == 0) push(1, 1);
      if ($urandom_range(0, 40) == 0) src0_phone = 8'($urandom);
      if ($urandom_range(0, 40) == 0) src1_phone = 8'($urandom);
      step();
    end
    chk("rand_progress", {31'd0, m_pkts > 10}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
